// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes one RV32I instruction per accepted beat into an ALU
// opcode, operands and writeback/branch metadata. A main register drives the
// outputs and a skid register absorbs one extra beat, so in_ready is a flop.
module alu_issue_stage #(
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] out_pc,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        is_branch,
  output logic        illegal
);

  typedef enum logic [4:0] {
    ALU_AND    = 5'd0,
    ALU_OR     = 5'd1,
    ALU_ADD    = 5'd2,
    ALU_XOR    = 5'd3,
    ALU_SLL    = 5'd4,
    ALU_SRL    = 5'd5,
    ALU_SUB    = 5'd6,
    ALU_SLT    = 5'd7,
    ALU_SGE    = 5'd8,
    ALU_PASS_A = 5'd9,
    ALU_PASS_B = 5'd10,
    ALU_EQ     = 5'd11,
    ALU_NE     = 5'd12,
    ALU_SLTU   = 5'd13,
    ALU_SGEU   = 5'd14,
    ALU_SRA    = 5'd15
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_e;

  typedef struct packed {
    alu_op_e     ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } beat_t;

  // funct3 map shared by OP and OP-IMM; alt selects SUB/SRA
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_u, shamt;
  beat_t       dec;
  beat_t       main_q, skid_q;
  logic        main_valid, skid_valid;
  logic        accept;

  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign shamt = {27'b0, in_instr[24:20]};

  // Combinational decode of the incoming instruction into a beat
  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    case (in_instr[6:0])
      OPC_OP: begin
        dec.a  = in_rs1_val;
        dec.b  = in_rs2_val;
        dec.we = 1'b1;
        if (f7 == 7'b0000000)
          dec.ctl = arith_op(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          dec.ctl = arith_op(f3, 1'b1);
        else
          dec.ill = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.a  = in_rs1_val;
        dec.we = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.b = shamt;
          if (f7 == 7'b0000000)
            dec.ctl = arith_op(f3, 1'b0);
          else if (f7 == 7'b0100000 && f3 == 3'b101)
            dec.ctl = ALU_SRA;
          else
            dec.ill = 1'b1;
        end else begin
          dec.b   = imm_i;
          dec.ctl = arith_op(f3, 1'b0);
        end
      end
      OPC_LUI: begin
        dec.ctl = ALU_PASS_B;
        dec.b   = imm_u;
        dec.we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.ctl = ALU_ADD;
        dec.a   = in_pc;
        dec.b   = imm_u;
        dec.we  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.ctl = ALU_ADD;
        dec.a   = in_pc;
        dec.b   = LINK_OFFSET;
        dec.we  = 1'b1;
      end
      OPC_BRANCH: begin
        dec.a  = in_rs1_val;
        dec.b  = in_rs2_val;
        dec.br = 1'b1;
        case (f3)
          3'b000:  dec.ctl = ALU_EQ;
          3'b001:  dec.ctl = ALU_NE;
          3'b100:  dec.ctl = ALU_SLT;
          3'b101:  dec.ctl = ALU_SGE;
          3'b110:  dec.ctl = ALU_SLTU;
          3'b111:  dec.ctl = ALU_SGEU;
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.ctl = ALU_ADD;
        dec.a   = in_rs1_val;
        dec.b   = imm_i;
        dec.we  = 1'b1;
      end
      OPC_STORE: begin
        dec.ctl = ALU_ADD;
        dec.a   = in_rs1_val;
        dec.b   = imm_s;
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal beats carry only pc/rd and the flag; x0 never gets written
    if (dec.ill) begin
      dec.ctl = ALU_AND;
      dec.a   = '0;
      dec.b   = '0;
      dec.we  = 1'b0;
      dec.br  = 1'b0;
    end
    if (dec.rd == 5'd0)
      dec.we = 1'b0;
  end

  assign accept = in_valid & in_ready;

  // Main/skid storage: skid drains into main first, so order is preserved
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept)
          main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign alu_ctl   = main_q.ctl;
  assign alu_a     = main_q.a;
  assign alu_b     = main_q.b;
  assign out_pc    = main_q.pc;
  assign rd        = main_q.rd;
  assign rd_we     = main_q.we;
  assign is_branch = main_q.br;
  assign illegal   = main_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run, all
// checked against an instruction-level reference decode and a beat queue.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, out_pc;
  logic [4:0]  rd;
  logic        rd_we, is_branch, illegal;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   tests   = 0;
  int   fails   = 0;
  int   retired = 0;

  alu_issue_stage #(.LINK_OFFSET(32'd4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .out_pc(out_pc),
    .rd(rd), .rd_we(rd_we), .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Instruction-level meaning of each RV32I class, in terms of the ALU codes
  function automatic logic [4:0] op_for_f3(input logic [2:0] f3);
    case (f3)
      3'd0: return 5'd2;   // ADD
      3'd1: return 5'd4;   // SLL
      3'd2: return 5'd7;   // SLT
      3'd3: return 5'd13;  // SLTU
      3'd4: return 5'd3;   // XOR
      3'd5: return 5'd5;   // SRL
      3'd6: return 5'd1;   // OR
      default: return 5'd0; // AND
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, pc, r1, r2);
    exp_t        e;
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] immi = 32'($signed(ins[31:20]));
    logic [31:0] imms = 32'($signed({ins[31:25], ins[11:7]}));
    logic [31:0] immu = ins[31:12] * 32'd4096;
    logic        ill = 1'b0;
    logic        wr  = 1'b0;
    e = '0;
    e.pc = pc;
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; wr = 1'b1;
        if (f7 == 7'h00) e.ctl = op_for_f3(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) e.ctl = 5'd6;
        else if (f7 == 7'h20 && f3 == 3'd5) e.ctl = 5'd15;
        else ill = 1'b1;
      end
      7'h13: begin
        e.a = r1; wr = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = 32'(ins[24:20]);
          if (f7 == 7'h00) e.ctl = op_for_f3(f3);
          else if (f7 == 7'h20 && f3 == 3'd5) e.ctl = 5'd15;
          else ill = 1'b1;
        end else begin
          e.b = immi; e.ctl = op_for_f3(f3);
        end
      end
      7'h37: begin e.ctl = 5'd10; e.b = immu; wr = 1'b1; end
      7'h17: begin e.ctl = 5'd2; e.a = pc; e.b = immu; wr = 1'b1; end
      7'h6F, 7'h67: begin e.ctl = 5'd2; e.a = pc; e.b = 32'd4; wr = 1'b1; end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1'b1;
        case (f3)
          3'd0: e.ctl = 5'd11;
          3'd1: e.ctl = 5'd12;
          3'd4: e.ctl = 5'd7;
          3'd5: e.ctl = 5'd8;
          3'd6: e.ctl = 5'd13;
          3'd7: e.ctl = 5'd14;
          default: ill = 1'b1;
        endcase
      end
      7'h03: begin e.ctl = 5'd2; e.a = r1; e.b = immi; wr = 1'b1; end
      7'h23: begin e.ctl = 5'd2; e.a = r1; e.b = imms; end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e.ctl = 5'd0; e.a = '0; e.b = '0; e.br = 1'b0; wr = 1'b0;
    end
    e.ill = ill;
    e.we  = wr && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      4: w[6:0] = 7'h6F;
      5: w[6:0] = 7'h67;
      6: w[6:0] = 7'h63;
      7: w[6:0] = 7'h03;
      8: w[6:0] = 7'h23;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // One clock of traffic: beat-level scoreboard plus occupancy-derived handshake
  task automatic drive_cycle();
    exp_t got, want;
    tests++;
    if (in_ready !== (q.size() < 2)) begin
      fails++; $display("FAIL in_ready: got %b want %b", in_ready, q.size() < 2);
    end
    tests++;
    if (out_valid !== (q.size() > 0)) begin
      fails++; $display("FAIL out_valid: got %b want %b", out_valid, q.size() > 0);
    end
    if (!flush) begin
      if (out_valid && out_ready && q.size() > 0) begin
        got  = {alu_ctl, alu_a, alu_b, out_pc, rd, rd_we, is_branch, illegal};
        want = q.pop_front();
        retired++;
        tests++;
        if (got !== want) begin
          fails++; $display("FAIL beat: got %h want %h", got, want);
        end
      end
      if (in_valid && in_ready)
        q.push_back(ref_decode(in_instr, in_pc, in_rs1_val, in_rs2_val));
    end
    @(posedge clk); #1;
    if (flush) q.delete();
  endtask

  task automatic issue(input logic [31:0] ins, pc, r1, r2);
    in_instr = ins; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2;
    in_valid = 1'b1;
    drive_cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({out_valid, alu_ctl, alu_a, alu_b, out_pc, rd, rd_we, is_branch, illegal} !== '0) begin
      fails++; $display("FAIL reset_outputs: got ctl=%0d a=%h b=%h v=%b", alu_ctl, alu_a, alu_b, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    issue(32'h402081B3, 32'h100, 32'd10, 32'd3);  // SUB x3,x1,x2
    tests++;
    if ({out_valid, alu_ctl, alu_a, alu_b, rd, rd_we} !== {1'b1, 5'd6, 32'd10, 32'd3, 5'd3, 1'b1}) begin
      fails++; $display("FAIL sub: got v=%b ctl=%0d a=%0d b=%0d rd=%0d we=%b want 1/6/10/3/3/1",
                        out_valid, alu_ctl, alu_a, alu_b, rd, rd_we);
    end
    issue(32'h40435293, 32'h104, 32'h80000000, 32'd0);  // SRAI x5,x6,4
    tests++;
    if ({alu_ctl, alu_a, alu_b, illegal} !== {5'd15, 32'h80000000, 32'd4, 1'b0}) begin
      fails++; $display("FAIL srai: got ctl=%0d a=%h b=%h ill=%b want 15/80000000/4/0",
                        alu_ctl, alu_a, alu_b, illegal);
    end
    issue(32'h123453B7, 32'h108, 32'd5, 32'd6);  // LUI x7,0x12345
    tests++;
    if ({alu_ctl, alu_a, alu_b} !== {5'd10, 32'd0, 32'h12345000}) begin
      fails++; $display("FAIL lui: got ctl=%0d a=%h b=%h want 10/0/12345000", alu_ctl, alu_a, alu_b);
    end
    issue(32'h0020E463, 32'h10C, 32'd1, 32'd2);  // BLTU x1,x2,8
    tests++;
    if ({alu_ctl, is_branch, rd_we, illegal} !== {5'd13, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL bltu: got ctl=%0d br=%b we=%b ill=%b want 13/1/0/0",
                        alu_ctl, is_branch, rd_we, illegal);
    end
    issue(32'h0020A463, 32'h110, 32'd1, 32'd2);  // branch funct3=010
    tests++;
    if ({illegal, alu_ctl, alu_a, alu_b, is_branch} !== {1'b1, 5'd0, 32'd0, 32'd0, 1'b0}) begin
      fails++; $display("FAIL branch_010: got ill=%b ctl=%0d a=%h b=%h br=%b want 1/0/0/0/0",
                        illegal, alu_ctl, alu_a, alu_b, is_branch);
    end
    issue(32'h004000EF, 32'h200, 32'd0, 32'd0);  // JAL x1,4
    tests++;
    if ({alu_ctl, alu_a, alu_b, rd_we} !== {5'd2, 32'h200, 32'd4, 1'b1}) begin
      fails++; $display("FAIL jal: got ctl=%0d a=%h b=%h we=%b want 2/200/4/1", alu_ctl, alu_a, alu_b, rd_we);
    end
    issue(32'h00100013, 32'h204, 32'd9, 32'd0);  // ADDI x0,x0,1: rd=0 never written
    tests++;
    if ({rd, rd_we} !== {5'd0, 1'b0}) begin
      fails++; $display("FAIL rd_zero: got rd=%0d we=%b want 0/0", rd, rd_we);
    end
    drive_cycle();
  endtask

  task automatic test_back_to_back();
    int base = retired;
    logic acc;
    out_ready = 1'b0;
    issue(32'h00100093, 32'h300, 32'd0, 32'd0);  // ADDI x1,x0,1
    issue(32'h00200113, 32'h304, 32'd0, 32'd0);  // ADDI x2,x0,2
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL stall_ready: got %b want 0", in_ready);
    end
    in_instr = 32'h00300193; in_pc = 32'h308; in_valid = 1'b1;  // ADDI x3,x0,3
    drive_cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && in_valid; i++) begin
      acc = in_ready;
      drive_cycle();
      if (acc) in_valid = 1'b0;
    end
    for (int i = 0; i < 5; i++) drive_cycle();
    tests++;
    if (retired - base !== 3) begin
      fails++; $display("FAIL stall_count: got %0d beats want 3", retired - base);
    end
  endtask

  task automatic test_flush();
    int base = retired;
    out_ready = 1'b0;
    issue(32'h00100093, 32'h400, 32'd0, 32'd0);
    issue(32'h00200113, 32'h404, 32'd0, 32'd0);
    in_instr = 32'h00300193; in_pc = 32'h408; in_valid = 1'b1;
    flush = 1'b1;
    drive_cycle();
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL flush_state: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive_cycle();
    tests++;
    if (retired != base) begin
      fails++; $display("FAIL flush_leak: got %0d beats want 0", retired - base);
    end
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    issue(32'h00100093, 32'h500, 32'd0, 32'd0);
    issue(32'h00200113, 32'h504, 32'd0, 32'd0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, alu_ctl, alu_a, alu_b, out_pc, rd, rd_we, is_branch, illegal} !== '0) begin
      fails++; $display("FAIL rst_midstall: got v=%b ctl=%0d a=%h pc=%h want all 0",
                        out_valid, alu_ctl, alu_a, out_pc);
    end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    issue(32'h40435293, 32'h600, 32'h80000000, 32'd0);
    tests++;
    if ({out_valid, alu_ctl, alu_b, out_pc} !== {1'b1, 5'd15, 32'd4, 32'h600}) begin
      fails++; $display("FAIL post_rst_beat: got v=%b ctl=%0d b=%h pc=%h want 1/15/4/600",
                        out_valid, alu_ctl, alu_b, out_pc);
    end
    drive_cycle();
  endtask

  task automatic test_random();
    int base = retired;
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 99) < 3);
      in_instr   = rand_instr();
      in_pc      = $urandom;
      in_rs1_val = $urandom;
      in_rs2_val = $urandom;
      drive_cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_cycle();
    tests++;
    if (retired - base < 500) begin
      fails++; $display("FAIL random_throughput: got %0d beats want >=500", retired - base);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
    #1;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midstall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
